id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures one decoded instruction per cycle for the execute stage.
// Detects load-use hazards and stalls fetch/decode for one cycle.
// Forwards same-cycle writeback data into captured operands.
// Squashes the incoming instruction when a branch is taken.
// Keeps a saturating stall counter for bring-up.
module id_ex_stage #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [3:0]        opcode_i,
  input  logic [3:0]        alu_inst_i,
  input  logic              imm_flag_i,
  input  logic [2:0]        imm_i,
  input  logic [2:0]        reg1_sel_i,
  input  logic [2:0]        reg2_sel_i,
  input  logic [2:0]        dest_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic [DATA_W-1:0] regd_data_i,
  input  logic              write_reg_i,
  input  logic              write_mem_i,
  input  logic              read_mem_i,
  input  logic [PC_W-1:0]   jmploc_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              wb_write_i,
  input  logic [2:0]        wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              valid_o,
  output logic [3:0]        opcode_o,
  output logic [3:0]        alu_inst_o,
  output logic              imm_flag_o,
  output logic [2:0]        imm_o,
  output logic [2:0]        dest_o,
  output logic [DATA_W-1:0] reg1_data_o,
  output logic [DATA_W-1:0] reg2_data_o,
  output logic [DATA_W-1:0] regd_data_o,
  output logic              write_reg_o,
  output logic              write_mem_o,
  output logic              read_mem_o,
  output logic [PC_W-1:0]   jmploc_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              stall_o,
  output logic [7:0]        stall_count_o
);

  logic              match1;
  logic              match2;
  logic              loadBubble;
  logic [DATA_W-1:0] reg1Fwd;
  logic [DATA_W-1:0] reg2Fwd;
  logic [DATA_W-1:0] regdFwd;

  // Load-use hazard: the load in execute writes a register the decode instruction reads.
  // An immediate-format instruction does not read reg2, so reg2 cannot create a hazard.
  always_comb begin
    match1     = (dest_o == reg1_sel_i);
    match2     = (dest_o == reg2_sel_i) && !imm_flag_i;
    stall_o    = valid_o && read_mem_o && write_reg_o && valid_i && !flush_i && (match1 || match2);
    loadBubble = flush_i || stall_o || !valid_i;
  end

  // Writeback bypass: the regfile write lands this cycle, so the read data is stale.
  always_comb begin
    reg1Fwd = (wb_write_i && (wb_dest_i == reg1_sel_i)) ? wb_data_i : reg1_data_i;
    reg2Fwd = (wb_write_i && (wb_dest_i == reg2_sel_i)) ? wb_data_i : reg2_data_i;
    regdFwd = (wb_write_i && (wb_dest_i == dest_i))     ? wb_data_i : regd_data_i;
  end

  // Pipeline register: reset and bubbles both clear every field so execute is deterministic.
  always_ff @(posedge clk) begin
    if (start_i || loadBubble) begin
      valid_o     <= 1'b0;
      opcode_o    <= '0;
      alu_inst_o  <= '0;
      imm_flag_o  <= 1'b0;
      imm_o       <= '0;
      dest_o      <= '0;
      reg1_data_o <= '0;
      reg2_data_o <= '0;
      regd_data_o <= '0;
      write_reg_o <= 1'b0;
      write_mem_o <= 1'b0;
      read_mem_o  <= 1'b0;
      jmploc_o    <= '0;
      pc_o        <= '0;
    end else begin
      valid_o     <= 1'b1;
      opcode_o    <= opcode_i;
      alu_inst_o  <= alu_inst_i;
      imm_flag_o  <= imm_flag_i;
      imm_o       <= imm_i;
      dest_o      <= dest_i;
      reg1_data_o <= reg1Fwd;
      reg2_data_o <= reg2Fwd;
      regd_data_o <= regdFwd;
      write_reg_o <= write_reg_i;
      write_mem_o <= write_mem_i;
      read_mem_o  <= read_mem_i;
      jmploc_o    <= jmploc_i;
      pc_o        <= pc_i;
    end
  end

  // Saturating stall counter; holds at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (start_i) begin
      stall_count_o <= '0;
    end else if (stall_o && (stall_count_o != 8'hFF)) begin
      stall_count_o <= stall_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage.
// A reference model predicts each cycle's outputs into a scoreboard queue.
// Each scenario task pops the queue after the clock edge and compares inline.
module tb_id_ex_stage;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    logic [3:0] aluInst;
    logic       immFlag;
    logic [2:0] imm;
    logic [2:0] dest;
    logic [7:0] reg1Data;
    logic [7:0] reg2Data;
    logic [7:0] regdData;
    logic       writeReg;
    logic       writeMem;
    logic       readMem;
    logic [15:0] jmploc;
    logic [15:0] pc;
    logic [7:0] stallCount;
  } outT;

  logic        clk;
  logic        start, valid, flush;
  logic [3:0]  opcode, aluInst;
  logic        immFlag;
  logic [2:0]  imm, reg1Sel, reg2Sel, dest;
  logic [7:0]  reg1Data, reg2Data, regdData;
  logic        writeReg, writeMem, readMem;
  logic [15:0] jmploc, pc;
  logic        wbWrite;
  logic [2:0]  wbDest;
  logic [7:0]  wbData;

  logic        validO, immFlagO, writeRegO, writeMemO, readMemO, stallO;
  logic [3:0]  opcodeO, aluInstO;
  logic [2:0]  immO, destO;
  logic [7:0]  reg1DataO, reg2DataO, regdDataO, stallCountO;
  logic [15:0] jmplocO, pcO;

  outT obs;
  outT modelOut;
  outT sb[$];
  int  checks;
  int  errors;

  id_ex_stage #(.DATA_W(8), .PC_W(16)) dut (
    .clk(clk), .start_i(start), .valid_i(valid), .flush_i(flush),
    .opcode_i(opcode), .alu_inst_i(aluInst), .imm_flag_i(immFlag), .imm_i(imm),
    .reg1_sel_i(reg1Sel), .reg2_sel_i(reg2Sel), .dest_i(dest),
    .reg1_data_i(reg1Data), .reg2_data_i(reg2Data), .regd_data_i(regdData),
    .write_reg_i(writeReg), .write_mem_i(writeMem), .read_mem_i(readMem),
    .jmploc_i(jmploc), .pc_i(pc),
    .wb_write_i(wbWrite), .wb_dest_i(wbDest), .wb_data_i(wbData),
    .valid_o(validO), .opcode_o(opcodeO), .alu_inst_o(aluInstO), .imm_flag_o(immFlagO),
    .imm_o(immO), .dest_o(destO), .reg1_data_o(reg1DataO), .reg2_data_o(reg2DataO),
    .regd_data_o(regdDataO), .write_reg_o(writeRegO), .write_mem_o(writeMemO),
    .read_mem_o(readMemO), .jmploc_o(jmplocO), .pc_o(pcO),
    .stall_o(stallO), .stall_count_o(stallCountO)
  );

  assign obs = {validO, opcodeO, aluInstO, immFlagO, immO, destO, reg1DataO, reg2DataO,
                regdDataO, writeRegO, writeMemO, readMemO, jmplocO, pcO, stallCountO};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference hazard rule evaluated on the model's execute-side state.
  function automatic logic modelStall();
    return modelOut.valid && modelOut.readMem && modelOut.writeReg && valid && !flush &&
           ((modelOut.dest == reg1Sel) || ((modelOut.dest == reg2Sel) && !immFlag));
  endfunction

  // Predict the next register state, push it, then advance one clock.
  task automatic tick();
    outT nxt;
    logic s;
    nxt = '0;
    if (!start) begin
      s = modelStall();
      nxt.stallCount = (s && modelOut.stallCount != 8'd255) ? modelOut.stallCount + 8'd1
                                                             : modelOut.stallCount;
      if (!flush && !s && valid) begin
        nxt.valid    = 1'b1;
        nxt.opcode   = opcode;
        nxt.aluInst  = aluInst;
        nxt.immFlag  = immFlag;
        nxt.imm      = imm;
        nxt.dest     = dest;
        nxt.reg1Data = (wbWrite && wbDest == reg1Sel) ? wbData : reg1Data;
        nxt.reg2Data = (wbWrite && wbDest == reg2Sel) ? wbData : reg2Data;
        nxt.regdData = (wbWrite && wbDest == dest)    ? wbData : regdData;
        nxt.writeReg = writeReg;
        nxt.writeMem = writeMem;
        nxt.readMem  = readMem;
        nxt.jmploc   = jmploc;
        nxt.pc       = pc;
      end
    end
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    modelOut = nxt;
  endtask

  task automatic clearInputs();
    start = 0; valid = 0; flush = 0; opcode = 0; aluInst = 0; immFlag = 0; imm = 0;
    reg1Sel = 0; reg2Sel = 0; dest = 0; reg1Data = 0; reg2Data = 0; regdData = 0;
    writeReg = 0; writeMem = 0; readMem = 0; jmploc = 0; pc = 0;
    wbWrite = 0; wbDest = 0; wbData = 0;
  endtask

  task automatic randomInputs();
    valid = 1'($urandom); flush = ($urandom_range(0, 3) == 0);
    opcode = 4'($urandom); aluInst = 4'($urandom); immFlag = 1'($urandom); imm = 3'($urandom);
    reg1Sel = 3'($urandom); reg2Sel = 3'($urandom); dest = 3'($urandom);
    reg1Data = 8'($urandom); reg2Data = 8'($urandom); regdData = 8'($urandom);
    writeReg = 1'($urandom); writeMem = 1'($urandom); readMem = 1'($urandom);
    jmploc = 16'($urandom); pc = 16'($urandom);
    wbWrite = 1'($urandom); wbDest = 3'($urandom); wbData = 8'($urandom);
  endtask

  task automatic loadInstr(input logic [2:0] d);
    clearInputs();
    valid = 1; readMem = 1; writeReg = 1; dest = d; opcode = 4'h8; pc = 16'h0010;
  endtask

  task automatic test_reset();
    outT expOut;
    randomInputs();
    start = 1; valid = 1;
    tick();
    expOut = sb.pop_front();
    checks++;
    if (obs !== expOut || obs !== '0) begin
      errors++; $display("[TB] FAIL reset outputs: got %h expected %h", obs, expOut);
    end
    clearInputs();
    #1;
    checks++;
    if (stallO !== 1'b0) begin
      errors++; $display("[TB] FAIL reset stall: got %b expected 0", stallO);
    end
  endtask

  task automatic test_passthrough();
    outT expOut;
    clearInputs();
    valid = 1; opcode = 4'h3; dest = 3'd2; reg1Data = 8'h12; pc = 16'h0005;
    #1;
    checks++;
    if (stallO !== modelStall()) begin
      errors++; $display("[TB] FAIL pass stall: got %b expected %b", stallO, modelStall());
    end
    tick();
    expOut = sb.pop_front();
    checks++;
    if (obs !== expOut) begin
      errors++; $display("[TB] FAIL pass outputs: got %h expected %h", obs, expOut);
    end
    checks++;
    if (validO !== 1'b1 || opcodeO !== 4'h3 || destO !== 3'd2 || reg1DataO !== 8'h12 || pcO !== 16'h0005) begin
      errors++; $display("[TB] FAIL pass fields: got v%b op%h d%0d r1 %h pc %h expected v1 op3 d2 r1 12 pc 0005",
                         validO, opcodeO, destO, reg1DataO, pcO);
    end
  endtask

  task automatic test_random();
    outT expOut;
    for (int i = 0; i < 40; i++) begin
      randomInputs();
      #1;
      checks++;
      if (stallO !== modelStall()) begin
        errors++; $display("[TB] FAIL random stall %0d: got %b expected %b", i, stallO, modelStall());
      end
      tick();
      expOut = sb.pop_front();
      checks++;
      if (obs !== expOut) begin
        errors++; $display("[TB] FAIL random outputs %0d: got %h expected %h", i, obs, expOut);
      end
    end
  endtask

  task automatic test_load_use();
    outT expOut;
    clearInputs();
    start = 1;
    tick();
    expOut = sb.pop_front();
    loadInstr(3'd3);
    tick();
    expOut = sb.pop_front();
    clearInputs();
    valid = 1; writeReg = 1; reg1Sel = 3'd3; reg2Sel = 3'd6; dest = 3'd4; opcode = 4'h1; pc = 16'h0011;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (stallO !== (i == 0) || stallO !== modelStall()) begin
        errors++; $display("[TB] FAIL loaduse stall %0d: got %b expected %b", i, stallO, (i == 0));
      end
      tick();
      expOut = sb.pop_front();
      checks++;
      if (obs !== expOut) begin
        errors++; $display("[TB] FAIL loaduse outputs %0d: got %h expected %h", i, obs, expOut);
      end
      checks++;
      if (validO !== (i == 1) || writeRegO !== (i == 1) || stallCountO !== 8'd1) begin
        errors++; $display("[TB] FAIL loaduse bubble %0d: got v%b wr%b cnt%0d expected v%b wr%b cnt1",
                           i, validO, writeRegO, stallCountO, (i == 1), (i == 1));
      end
    end
  endtask

  task automatic test_imm_no_stall();
    outT expOut;
    loadInstr(3'd3);
    tick();
    expOut = sb.pop_front();
    clearInputs();
    valid = 1; writeReg = 1; immFlag = 1; imm = 3'd5; reg1Sel = 3'd1; reg2Sel = 3'd3; dest = 3'd2;
    #1;
    checks++;
    if (stallO !== 1'b0) begin
      errors++; $display("[TB] FAIL imm stall: got %b expected 0", stallO);
    end
    tick();
    expOut = sb.pop_front();
    checks++;
    if (obs !== expOut || validO !== 1'b1) begin
      errors++; $display("[TB] FAIL imm outputs: got %h expected %h", obs, expOut);
    end
  endtask

  task automatic test_bypass();
    outT expOut;
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      valid = 1; wbWrite = (i != 2); wbDest = 3'd5; wbData = 8'hA5;
      reg1Sel = (i == 1) ? 3'd5 : 3'd0; reg2Sel = 3'd5; dest = (i == 1) ? 3'd5 : 3'd1;
      reg1Data = 8'h11; reg2Data = 8'h00; regdData = 8'h33;
      tick();
      expOut = sb.pop_front();
      checks++;
      if (obs !== expOut) begin
        errors++; $display("[TB] FAIL bypass outputs %0d: got %h expected %h", i, obs, expOut);
      end
      checks++;
      if (reg2DataO !== ((i == 2) ? 8'h00 : 8'hA5)) begin
        errors++; $display("[TB] FAIL bypass reg2 %0d: got %h expected %h", i, reg2DataO,
                           (i == 2) ? 8'h00 : 8'hA5);
      end
    end
  endtask

  task automatic test_flush();
    outT expOut;
    logic [7:0] cntBefore;
    loadInstr(3'd3);
    tick();
    expOut = sb.pop_front();
    cntBefore = modelOut.stallCount;
    clearInputs();
    valid = 1; writeReg = 1; reg1Sel = 3'd3; flush = 1; opcode = 4'h2;
    #1;
    checks++;
    if (stallO !== 1'b0) begin
      errors++; $display("[TB] FAIL flush stall: got %b expected 0", stallO);
    end
    tick();
    expOut = sb.pop_front();
    checks++;
    if (obs !== expOut || validO !== 1'b0 || stallCountO !== cntBefore) begin
      errors++; $display("[TB] FAIL flush outputs: got %h expected %h", obs, expOut);
    end
  endtask

  task automatic test_saturation();
    outT expOut;
    loadInstr(3'd3);
    reg1Sel = 3'd3;
    for (int i = 0; i < 600; i++) begin
      #1;
      checks++;
      if (stallO !== modelStall()) begin
        errors++; $display("[TB] FAIL sat stall %0d: got %b expected %b", i, stallO, modelStall());
      end
      tick();
      expOut = sb.pop_front();
      checks++;
      if (obs !== expOut) begin
        errors++; $display("[TB] FAIL sat outputs %0d: got %h expected %h", i, obs, expOut);
      end
    end
    checks++;
    if (stallCountO !== 8'd255) begin
      errors++; $display("[TB] FAIL sat count: got %0d expected 255", stallCountO);
    end
  endtask

  task automatic test_reset_mid_stall();
    outT expOut;
    clearInputs();
    tick();
    expOut = sb.pop_front();
    loadInstr(3'd4);
    tick();
    expOut = sb.pop_front();
    clearInputs();
    valid = 1; writeReg = 1; reg2Sel = 3'd4; dest = 3'd7; opcode = 4'h5; pc = 16'h0020;
    #1;
    checks++;
    if (stallO !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset stall: got %b expected 1", stallO);
    end
    start = 1;
    tick();
    expOut = sb.pop_front();
    checks++;
    if (obs !== expOut || stallCountO !== 8'd0) begin
      errors++; $display("[TB] FAIL midreset outputs: got %h expected %h", obs, expOut);
    end
    start = 0;
    #1;
    checks++;
    if (stallO !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset restall: got %b expected 0", stallO);
    end
    tick();
    expOut = sb.pop_front();
    checks++;
    if (obs !== expOut || validO !== 1'b1 || pcO !== 16'h0020) begin
      errors++; $display("[TB] FAIL midreset replay: got %h expected %h", obs, expOut);
    end
  endtask

  // Run all scenarios in sequence, then report.
  initial begin
    checks = 0;
    errors = 0;
    modelOut = '0;
    clearInputs();
    @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_random();
    test_load_use();
    test_imm_no_stall();
    test_bypass();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
